// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: reset/write
// encodings, arbiter FSM states and the hard-wired zero register.
package writeback_arbiter_pkg;

    localparam logic RESET_ENABLE  = 1'b1;
    localparam logic RESET_DISABLE = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [4:0] REGISTER_ZERO = 5'b0;

    typedef enum logic {
        ARB_STATE_NORMAL       = 1'b0,
        ARB_STATE_DIV_PRIORITY = 1'b1
    } arb_state_t;

    // r0 is hard-wired, so a write to it never needs the port
    function automatic logic is_real_register(input logic [4:0] address);
        return address != REGISTER_ZERO;
    endfunction

endpackage

// File: rtl/writeback_arbiter_busy_scoreboard.sv
// 32-entry busy vector for registers awaiting a divider result, with the
// issue check and the two decode-source lookups.
module writeback_arbiter_busy_scoreboard
    import writeback_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       issue_enable,
    input  logic [4:0] issue_address,
    output logic       issue_ready,
    input  logic       clear_enable,
    input  logic [4:0] clear_address,
    input  logic [4:0] read_address_a,
    input  logic [4:0] read_address_b,
    output logic       busy_a,
    output logic       busy_b
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    assign issue_ready = !busy_q[issue_address];
    assign busy_a      = busy_q[read_address_a];
    assign busy_b      = busy_q[read_address_b];

    // A busy address is never issue_ready, so set and clear cannot collide
    always_comb begin
        busy_d = busy_q;
        if (clear_enable) begin
            busy_d[clear_address] = 1'b0;
        end
        if (issue_enable && issue_ready && is_real_register(issue_address)) begin
            busy_d[issue_address] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and the divider, with an anti-starvation priority state for the divider.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int MAX_WAIT   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_write_enable,
    input  logic [4:0]            pipe_write_address,
    input  logic [DATA_WIDTH-1:0] pipe_write_data,
    output logic                  pipe_stall,
    input  logic                  div_valid,
    input  logic [4:0]            div_address,
    input  logic [DATA_WIDTH-1:0] div_data,
    output logic                  div_ready,
    input  logic                  issue_enable,
    input  logic [4:0]            issue_address,
    output logic                  issue_ready,
    input  logic [4:0]            read_address_a,
    input  logic [4:0]            read_address_b,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic                  rf_write_enable,
    output logic [4:0]            rf_write_address,
    output logic [DATA_WIDTH-1:0] rf_write_data
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT - 1);

    arb_state_t            state_q, state_d;
    logic [3:0]            wait_count_q, wait_count_d;
    logic                  rf_write_enable_q, rf_write_enable_d;
    logic [4:0]            rf_write_address_q, rf_write_address_d;
    logic [DATA_WIDTH-1:0] rf_write_data_q, rf_write_data_d;

    logic active;
    logic pipe_effective;
    logic handshake;
    logic pipe_wins;
    logic div_writes;
    logic busy_a;
    logic busy_b;

    assign active         = (reset == RESET_DISABLE);
    assign pipe_effective = pipe_write_enable && is_real_register(pipe_write_address);

    assign pipe_stall = active && (state_q == ARB_STATE_DIV_PRIORITY);
    assign div_ready  = active && ((state_q == ARB_STATE_DIV_PRIORITY) || !pipe_effective);
    assign handshake  = div_valid && div_ready;
    assign pipe_wins  = pipe_effective && !pipe_stall;
    assign div_writes = handshake && is_real_register(div_address);

    assign hazard_a = active && busy_a;
    assign hazard_b = active && busy_b;

    writeback_arbiter_busy_scoreboard u_busy_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .issue_enable   (issue_enable),
        .issue_address  (issue_address),
        .issue_ready    (issue_ready),
        .clear_enable   (handshake),
        .clear_address  (div_address),
        .read_address_a (read_address_a),
        .read_address_b (read_address_b),
        .busy_a         (busy_a),
        .busy_b         (busy_b)
    );

    // The divider is refused only in NORMAL; once refused MAX_WAIT times in a
    // row it gets one priority cycle in which the pipeline stalls.
    always_comb begin
        state_d      = state_q;
        wait_count_d = wait_count_q;
        case (state_q)
            ARB_STATE_NORMAL: begin
                if (div_valid && !div_ready) begin
                    wait_count_d = wait_count_q + 4'd1;
                    if (wait_count_q == WAIT_LIMIT) begin
                        state_d = ARB_STATE_DIV_PRIORITY;
                    end
                end else begin
                    wait_count_d = 4'd0;
                end
            end
            ARB_STATE_DIV_PRIORITY: begin
                if (handshake || !div_valid) begin
                    state_d      = ARB_STATE_NORMAL;
                    wait_count_d = 4'd0;
                end
            end
            default: begin
                state_d      = ARB_STATE_NORMAL;
                wait_count_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        rf_write_enable_d  = WRITE_DISABLE;
        rf_write_address_d = rf_write_address_q;
        rf_write_data_d    = rf_write_data_q;
        if (pipe_wins) begin
            rf_write_enable_d  = WRITE_ENABLE;
            rf_write_address_d = pipe_write_address;
            rf_write_data_d    = pipe_write_data;
        end else if (div_writes) begin
            rf_write_enable_d  = WRITE_ENABLE;
            rf_write_address_d = div_address;
            rf_write_data_d    = div_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            state_q            <= ARB_STATE_NORMAL;
            wait_count_q       <= 4'd0;
            rf_write_enable_q  <= WRITE_DISABLE;
            rf_write_address_q <= REGISTER_ZERO;
            rf_write_data_q    <= '0;
        end else begin
            state_q            <= state_d;
            wait_count_q       <= wait_count_d;
            rf_write_enable_q  <= rf_write_enable_d;
            rf_write_address_q <= rf_write_address_d;
            rf_write_data_q    <= rf_write_data_d;
        end
    end

    assign rf_write_enable  = rf_write_enable_q;
    assign rf_write_address = rf_write_address_q;
    assign rf_write_data    = rf_write_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected register-file writes are
// queued by the stimulus and matched by a monitor on every rf write.
module tb_writeback_arbiter;

    logic        clock;
    logic        reset;
    logic        pipe_write_enable;
    logic [4:0]  pipe_write_address;
    logic [31:0] pipe_write_data;
    logic        pipe_stall;
    logic        div_valid;
    logic [4:0]  div_address;
    logic [31:0] div_data;
    logic        div_ready;
    logic        issue_enable;
    logic [4:0]  issue_address;
    logic        issue_ready;
    logic [4:0]  read_address_a;
    logic [4:0]  read_address_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;

    int compared   = 0;
    int mismatched = 0;

    logic [36:0] expected_q[$];

    writeback_arbiter #(.MAX_WAIT(4), .DATA_WIDTH(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .pipe_write_enable  (pipe_write_enable),
        .pipe_write_address (pipe_write_address),
        .pipe_write_data    (pipe_write_data),
        .pipe_stall         (pipe_stall),
        .div_valid          (div_valid),
        .div_address        (div_address),
        .div_data           (div_data),
        .div_ready          (div_ready),
        .issue_enable       (issue_enable),
        .issue_address      (issue_address),
        .issue_ready        (issue_ready),
        .read_address_a     (read_address_a),
        .read_address_b     (read_address_b),
        .hazard_a           (hazard_a),
        .hazard_b           (hazard_b),
        .rf_write_enable    (rf_write_enable),
        .rf_write_address   (rf_write_address),
        .rf_write_data      (rf_write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expect_write(input logic [4:0] address, input logic [31:0] data);
        expected_q.push_back({address, data});
    endtask

    // Monitor: every register-file write must match the oldest queued entry
    always @(posedge clock) begin
        #2;
        if (rf_write_enable === 1'b1) begin
            if (expected_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write at %0t",
                         rf_write_address, rf_write_data, $time);
            end else begin
                logic [36:0] e;
                e = expected_q.pop_front();
                check("rf_write_address", 32'(rf_write_address), 32'(e[36:32]));
                check("rf_write_data", rf_write_data, e[31:0]);
            end
        end
    end

    initial begin
        reset              = 1'b1;
        pipe_write_enable  = 1'b0;
        pipe_write_address = 5'd0;
        pipe_write_data    = 32'd0;
        div_valid          = 1'b1;
        div_address        = 5'd3;
        div_data           = 32'h0000AAAA;
        issue_enable       = 1'b0;
        issue_address      = 5'd0;
        read_address_a     = 5'd0;
        read_address_b     = 5'd0;

        // Reset with a divider result pending
        repeat (2) @(negedge clock);
        #1;
        check("reset_div_ready", 32'(div_ready), 32'd0);
        check("reset_pipe_stall", 32'(pipe_stall), 32'd0);
        check("reset_hazard_a", 32'(hazard_a), 32'd0);
        check("reset_hazard_b", 32'(hazard_b), 32'd0);
        check("reset_rf_we", 32'(rf_write_enable), 32'd0);
        check("reset_rf_addr", 32'(rf_write_address), 32'd0);
        check("reset_rf_data", rf_write_data, 32'd0);

        // First cycle after release: divider accepted immediately
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("release_div_ready", 32'(div_ready), 32'd1);
        expect_write(5'd3, 32'h0000AAAA);

        // Lone pipeline write
        @(negedge clock);
        div_valid          = 1'b0;
        pipe_write_enable  = 1'b1;
        pipe_write_address = 5'd5;
        pipe_write_data    = 32'h1234;
        #1;
        check("pipe_alone_stall", 32'(pipe_stall), 32'd0);
        expect_write(5'd5, 32'h00001234);

        // Issue a divide to r7
        @(negedge clock);
        pipe_write_enable = 1'b0;
        issue_enable      = 1'b1;
        issue_address     = 5'd7;
        #1;
        check("issue_r7_ready", 32'(issue_ready), 32'd1);

        @(negedge clock);
        issue_enable   = 1'b0;
        read_address_a = 5'd7;
        #1;
        check("r7_busy_issue_ready", 32'(issue_ready), 32'd0);
        check("r7_hazard_a", 32'(hazard_a), 32'd1);
        check("r0_hazard_b", 32'(hazard_b), 32'd0);

        // Divider returns r7; hazard holds until the edge
        @(negedge clock);
        div_valid   = 1'b1;
        div_address = 5'd7;
        div_data    = 32'hDEAD;
        #1;
        check("r7_div_ready", 32'(div_ready), 32'd1);
        check("r7_hazard_during_write", 32'(hazard_a), 32'd1);
        expect_write(5'd7, 32'h0000DEAD);

        @(negedge clock);
        div_valid = 1'b0;
        #1;
        check("r7_hazard_cleared", 32'(hazard_a), 32'd0);
        check("r7_issue_ready_again", 32'(issue_ready), 32'd1);

        // Pipeline writes every cycle while the divider waits
        @(negedge clock);
        div_valid   = 1'b1;
        div_address = 5'd2;
        div_data    = 32'h2222;
        for (int k = 0; k < 4; k++) begin
            pipe_write_enable  = 1'b1;
            pipe_write_address = 5'(10 + k);
            pipe_write_data    = 32'h100 + 32'(k);
            #1;
            check("starve_div_ready", 32'(div_ready), 32'd0);
            check("starve_pipe_stall", 32'(pipe_stall), 32'd0);
            expect_write(5'(10 + k), 32'h100 + 32'(k));
            @(negedge clock);
        end
        pipe_write_address = 5'd14;
        pipe_write_data    = 32'h104;
        #1;
        check("priority_pipe_stall", 32'(pipe_stall), 32'd1);
        check("priority_div_ready", 32'(div_ready), 32'd1);
        expect_write(5'd2, 32'h2222);

        @(negedge clock);
        div_valid = 1'b0;
        #1;
        check("after_priority_stall", 32'(pipe_stall), 32'd0);
        expect_write(5'd14, 32'h104);

        // Pipeline write to r0 does not block the divider
        @(negedge clock);
        pipe_write_address = 5'd0;
        pipe_write_data    = 32'h9999;
        div_valid          = 1'b1;
        div_address        = 5'd3;
        div_data           = 32'h3333;
        #1;
        check("r0_pipe_div_ready", 32'(div_ready), 32'd1);
        check("r0_pipe_stall", 32'(pipe_stall), 32'd0);
        expect_write(5'd3, 32'h3333);

        // Divider handshake to r0 produces no write
        @(negedge clock);
        pipe_write_enable = 1'b0;
        div_address       = 5'd0;
        div_data          = 32'h5555;
        #1;
        check("div_r0_ready", 32'(div_ready), 32'd1);

        @(negedge clock);
        div_valid     = 1'b0;
        issue_enable  = 1'b1;
        issue_address = 5'd4;
        #1;
        check("div_r0_no_write", 32'(rf_write_enable), 32'd0);
        check("issue_r4_ready", 32'(issue_ready), 32'd1);

        // Set r9 and clear r4 in the same cycle
        @(negedge clock);
        issue_address  = 5'd9;
        div_valid      = 1'b1;
        div_address    = 5'd4;
        div_data       = 32'h4444;
        read_address_a = 5'd9;
        read_address_b = 5'd4;
        #1;
        check("issue_r9_ready", 32'(issue_ready), 32'd1);
        check("r4_hazard_b_before", 32'(hazard_b), 32'd1);
        check("r9_hazard_a_before", 32'(hazard_a), 32'd0);
        expect_write(5'd4, 32'h4444);

        @(negedge clock);
        issue_enable = 1'b0;
        div_valid    = 1'b0;
        #1;
        check("r9_busy_after", 32'(hazard_a), 32'd1);
        check("r4_clear_after", 32'(hazard_b), 32'd0);
        check("r9_issue_blocked", 32'(issue_ready), 32'd0);

        // Mid-sequence reset discards the pending result and busy bits
        @(negedge clock);
        reset       = 1'b1;
        div_valid   = 1'b1;
        div_address = 5'd9;
        div_data    = 32'h7777;
        #1;
        check("midreset_hazard_a", 32'(hazard_a), 32'd0);
        check("midreset_div_ready", 32'(div_ready), 32'd0);

        @(negedge clock);
        reset     = 1'b0;
        div_valid = 1'b0;
        #1;
        check("postreset_r9_hazard", 32'(hazard_a), 32'd0);
        check("postreset_r9_issue_ready", 32'(issue_ready), 32'd1);
        check("postreset_rf_we", 32'(rf_write_enable), 32'd0);

        repeat (3) @(negedge clock);
        check("queue_drained", 32'(expected_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
